// File: rtl/simple_pkg.sv
// Shared definitions for the execute->writeback stage.
// Branch condition codes, flag bit positions, skid-queue states.
package simple_pkg;

    localparam logic [2:0] BR_BE  = 3'b000;
    localparam logic [2:0] BR_BLT = 3'b001;
    localparam logic [2:0] BR_BLE = 3'b010;
    localparam logic [2:0] BR_BNE = 3'b011;
    localparam logic [2:0] BR_B   = 3'b111;

    localparam int FLG_S = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_TWO   = 2'd2
    } q_state_e;

    function automatic logic br_cond_met(
        input logic [2:0] cond,
        input logic [3:0] f
    );
        logic lt;
        lt = f[FLG_S] ^ f[FLG_V];
        case (cond)
            BR_BE:   br_cond_met = f[FLG_Z];
            BR_BLT:  br_cond_met = lt;
            BR_BLE:  br_cond_met = f[FLG_Z] | lt;
            BR_BNE:  br_cond_met = ~f[FLG_Z];
            BR_B:    br_cond_met = 1'b1;
            default: br_cond_met = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_wb_stage_fifo.sv
// Two-entry register-file write queue with valid/ready handshake.
// in_ready_o decodes the state register only, so it never sees out_ready_i.
module wb_skid_fifo
    import simple_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] res_i,
    input  logic [RW-1:0] rd_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] res_o,
    output logic [RW-1:0] rd_o
);

    q_state_e      state_q, state_d;
    logic [DW-1:0] head_res_q, head_res_d;
    logic [RW-1:0] head_rd_q, head_rd_d;
    logic [DW-1:0] tail_res_q, tail_res_d;
    logic [RW-1:0] tail_rd_q, tail_rd_d;
    logic          push;
    logic          pop;

    assign in_ready_o  = (state_q != Q_TWO);
    assign out_valid_o = (state_q != Q_EMPTY);
    assign res_o       = head_res_q;
    assign rd_o        = head_rd_q;
    assign push        = push_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // Next-state and entry movement for the queue.
    always_comb begin
        state_d    = state_q;
        head_res_d = head_res_q;
        head_rd_d  = head_rd_q;
        tail_res_d = tail_res_q;
        tail_rd_d  = tail_rd_q;
        case (state_q)
            Q_EMPTY: begin
                if (push) begin
                    head_res_d = res_i;
                    head_rd_d  = rd_i;
                    state_d    = Q_ONE;
                end
            end
            Q_ONE: begin
                if (push && pop) begin
                    head_res_d = res_i;
                    head_rd_d  = rd_i;
                end else if (push) begin
                    tail_res_d = res_i;
                    tail_rd_d  = rd_i;
                    state_d    = Q_TWO;
                end else if (pop) begin
                    state_d    = Q_EMPTY;
                end
            end
            Q_TWO: begin
                if (pop) begin
                    head_res_d = tail_res_q;
                    head_rd_d  = tail_rd_q;
                    state_d    = Q_ONE;
                end
            end
            default: state_d = Q_EMPTY;
        endcase
    end

    // Queue state and entry registers; reset drops any queued beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= Q_EMPTY;
            head_res_q <= '0;
            head_rd_q  <= '0;
            tail_res_q <= '0;
            tail_rd_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_res_q <= head_res_d;
            head_rd_q  <= head_rd_d;
            tail_res_q <= tail_res_d;
            tail_rd_q  <= tail_rd_d;
        end
    end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute->writeback stage: flag register, branch resolver, write queue.
// Optional upstream stall counter enabled by EXWB_STALL_CNT_EN.
module ex_wb_stage
    import simple_pkg::*;
#(
    parameter int DW   = 16,
    parameter int RW   = 3
`ifdef EXWB_STALL_CNT_EN
    ,
    parameter int CNTW = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_res,
    input  logic [3:0]      in_szcv,
    input  logic [RW-1:0]   in_rd,
    input  logic            in_wr_en,
    input  logic            in_set_flags,
    input  logic            in_is_br,
    input  logic [2:0]      in_br_cond,
    input  logic [DW-1:0]   in_br_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_res,
    output logic [RW-1:0]   out_rd,
    output logic [3:0]      flags,
    output logic            br_taken,
    output logic [DW-1:0]   br_target
`ifdef EXWB_STALL_CNT_EN
    ,
    output logic [CNTW-1:0] stall_cnt
`endif
);

    logic          accept;
    logic          take;
    logic [3:0]    flags_q;
    logic          br_taken_q;
    logic [DW-1:0] br_target_q;

    assign accept    = in_valid & in_ready;
    assign take      = accept & in_is_br & br_cond_met(in_br_cond, flags_q);
    assign flags     = flags_q;
    assign br_taken  = br_taken_q;
    assign br_target = br_target_q;

    wb_skid_fifo #(
        .DW (DW),
        .RW (RW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (in_valid & in_wr_en),
        .res_i       (in_res),
        .rd_i        (in_rd),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (out_res),
        .rd_o        (out_rd)
    );

    // Flag register and registered branch outcome; branches see pre-edge flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            if (accept && in_set_flags) flags_q <= in_szcv;
            br_taken_q <= take;
            if (take) br_target_q <= in_br_target;
        end
    end

`ifdef EXWB_STALL_CNT_EN
    logic [CNTW-1:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    // Saturating count of cycles where upstream is held off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (in_valid && !in_ready && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + CNTW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed and random checks of ex_wb_stage against a queue-based model.
// Stall-counter checks are compiled in with EXWB_STALL_CNT_EN.
module tb_ex_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_res;
    logic [3:0]  in_szcv;
    logic [2:0]  in_rd;
    logic        in_wr_en;
    logic        in_set_flags;
    logic        in_is_br;
    logic [2:0]  in_br_cond;
    logic [15:0] in_br_target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic [2:0]  out_rd;
    logic [3:0]  flags;
    logic        br_taken;
    logic [15:0] br_target;
`ifdef EXWB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    ex_wb_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_res       (in_res),
        .in_szcv      (in_szcv),
        .in_rd        (in_rd),
        .in_wr_en     (in_wr_en),
        .in_set_flags (in_set_flags),
        .in_is_br     (in_is_br),
        .in_br_cond   (in_br_cond),
        .in_br_target (in_br_target),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_rd       (out_rd),
        .flags        (flags),
        .br_taken     (br_taken),
        .br_target    (br_target)
`ifdef EXWB_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    typedef struct {
        logic [15:0] res;
        logic [2:0]  rd;
    } ent_t;

    ent_t        mq[$];
    logic [3:0]  m_flags;
    logic        m_br;
    logic [15:0] m_tgt;
    int unsigned m_stall;
    int          nchk = 0;
    int          nfail = 0;

    function automatic bit taken(input logic [2:0] c, input logic [3:0] f);
        bit s, z, v;
        s = f[3];
        z = f[2];
        v = f[0];
        case (c)
            3'd0:    return z;
            3'd1:    return s != v;
            3'd2:    return z || (s != v);
            3'd3:    return !z;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
        if (mq.size() > 0) begin
            check("out_res", {16'd0, out_res}, {16'd0, mq[0].res});
            check("out_rd", {29'd0, out_rd}, {29'd0, mq[0].rd});
        end
        check("flags", {28'd0, flags}, {28'd0, m_flags});
        check("br_taken", {31'd0, br_taken}, {31'd0, m_br});
        if (m_br) check("br_target", {16'd0, br_target}, {16'd0, m_tgt});
`ifdef EXWB_STALL_CNT_EN
        check("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
    endtask

    task automatic model_reset();
        mq.delete();
        m_flags = 4'd0;
        m_br    = 1'b0;
        m_tgt   = 16'd0;
        m_stall = 0;
    endtask

    task automatic drive_zero();
        in_valid     = 1'b0;
        in_res       = '0;
        in_szcv      = '0;
        in_rd        = '0;
        in_wr_en     = 1'b0;
        in_set_flags = 1'b0;
        in_is_br     = 1'b0;
        in_br_cond   = '0;
        in_br_target = '0;
    endtask

    // One clock: drive at negedge, advance model, check at next negedge.
    task automatic cyc(input bit v, input logic [15:0] res,
                       input logic [3:0] szcv, input logic [2:0] rd,
                       input bit wr, input bit sf, input bit br,
                       input logic [2:0] cond, input logic [15:0] tgt,
                       input bit ordy);
        bit acc, pop;
        in_valid     = v;
        in_res       = res;
        in_szcv      = szcv;
        in_rd        = rd;
        in_wr_en     = wr;
        in_set_flags = sf;
        in_is_br     = br;
        in_br_cond   = cond;
        in_br_target = tgt;
        out_ready    = ordy;
        acc = v && (mq.size() < 2);
        pop = (mq.size() > 0) && ordy;
        if (v && mq.size() == 2 && m_stall < 65535) m_stall++;
        m_br = acc && br && taken(cond, m_flags);
        if (m_br) m_tgt = tgt;
        if (acc && sf) m_flags = szcv;
        if (pop) void'(mq.pop_front());
        if (acc && wr) mq.push_back('{res, rd});
        @(negedge clk);
        check_all();
    endtask

    task automatic wr(input logic [15:0] res, input logic [2:0] rd,
                      input bit ordy);
        cyc(1, res, 4'd0, rd, 1, 0, 0, 3'd0, 16'd0, ordy);
    endtask

    task automatic cmp(input logic [3:0] szcv);
        cyc(1, 16'd0, szcv, 3'd0, 0, 1, 0, 3'd0, 16'd0, 1);
    endtask

    task automatic bra(input logic [2:0] cond, input logic [15:0] tgt);
        cyc(1, 16'd0, 4'd0, 3'd0, 0, 0, 1, cond, tgt, 1);
    endtask

    task automatic idle(input bit ordy);
        cyc(0, 16'd0, 4'd0, 3'd0, 0, 0, 0, 3'd0, 16'd0, ordy);
    endtask

    task automatic do_reset();
        drive_zero();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        drive_zero();
        out_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        check("rst_out_res", {16'd0, out_res}, 32'd0);
        check("rst_out_rd", {29'd0, out_rd}, 32'd0);
        check("rst_br_target", {16'd0, br_target}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // CMP sets Z, then BE is taken one cycle after accept
        cmp(4'b0100);
        check("cmp_flags", {28'd0, flags}, 32'h4);
        bra(3'b000, 16'h0040);
        check("be_taken", {31'd0, br_taken}, 32'd1);
        check("be_target", {16'd0, br_target}, 32'h0040);
        idle(1);
        check("be_pulse_end", {31'd0, br_taken}, 32'd0);

        // S=1,V=0: BLT and BNE taken; S=1,V=1: BLT not taken
        cmp(4'b1000);
        bra(3'b001, 16'h0100);
        check("blt_taken", {31'd0, br_taken}, 32'd1);
        bra(3'b011, 16'h0200);
        check("bne_taken", {31'd0, br_taken}, 32'd1);
        check("bne_target", {16'd0, br_target}, 32'h0200);
        cmp(4'b1001);
        bra(3'b001, 16'h0300);
        check("blt_not_taken", {31'd0, br_taken}, 32'd0);
        bra(3'b010, 16'h0400);
        bra(3'b101, 16'h0500);
        bra(3'b111, 16'h0600);
        idle(1);

        // Back-pressure: two queued writes drain in order
        idle(0);
        wr(16'h1234, 3'd1, 0);
        wr(16'h5678, 3'd2, 0);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        idle(0);
        check("hold_rd", {29'd0, out_rd}, 32'd1);
        check("hold_res", {16'd0, out_res}, 32'h1234);
        idle(1);
        check("drain2_rd", {29'd0, out_rd}, 32'd2);
        check("drain2_res", {16'd0, out_res}, 32'h5678);
        idle(1);
        check("drained", {31'd0, out_valid}, 32'd0);

        // Back-to-back writes at full rate
        for (int i = 0; i < 10; i++) begin
            wr(16'($urandom), 3'(i), 1);
            check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        end
        idle(1);

        // Reset with two beats queued and a branch pulse live
        cmp(4'b1111);
        idle(0);
        wr(16'hAAAA, 3'd3, 0);
        cyc(1, 16'hBBBB, 4'd0, 3'd4, 1, 0, 1, 3'd7, 16'h0777, 0);
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        check("pre_rst_br", {31'd0, br_taken}, 32'd1);
        do_reset();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        idle(1);

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom),
                3'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 2) == 0, 3'($urandom), 16'($urandom),
                $urandom_range(0, 3) != 0);
        end

`ifdef EXWB_STALL_CNT_EN
        do_reset();
        wr(16'h0001, 3'd1, 0);
        wr(16'h0002, 3'd2, 0);
        repeat (5) wr(16'h0003, 3'd3, 0);
        check("stall_5", {16'd0, stall_cnt}, 32'd5);
        for (int i = 0; i < 65540; i++) wr(16'h0004, 3'd4, 0);
        check("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
        idle(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
